// File: rtl/alu_md_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_md_pkg                                                           |
// | Shared encodings for the alu_md execution-unit ALU/MUL/DIV block.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_md_pkg;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ALU  = 3'd1,
        MUL  = 3'd2,
        DIV  = 3'd3,
        ERR  = 3'd4,
        FIN  = 3'd5
    } state_t;

    // 181 function selects; S_SUB and S_XOR share a code, the mode bit tells them apart.
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_OR  = 4'b1110;
    localparam logic [3:0] S_AND = 4'b1011;
    localparam logic [3:0] S_XOR = 4'b0110;
    localparam logic [3:0] S_A   = 4'b0000;

endpackage
`default_nettype wire

// File: rtl/alu_md_core_w.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_core_w                                                           |
// | Combinational W-bit 74181 array with 74182-style group lookahead.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_core_w
    import alu_md_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic [3:0]     i_s,
    input  logic           i_m,
    input  logic           i_cin_n,
    output logic [W-1:0]   o_f,
    output logic           o_carry,
    output logic [W/4-1:0] o_eq,
    output logic           o_c_msb
);

    localparam int C_NS = W / 4;

    logic [C_NS-1:0] w_gg;
    logic [C_NS-1:0] w_gp;
    logic [C_NS-1:0] w_cslice;
    logic            w_c0;

    // Flattened sum-of-products carry into slice k from the group G/P terms.
    function automatic logic f_cla(input logic [C_NS-1:0] gg, input logic [C_NS-1:0] gp,
                                   input logic c0, input int k);
        logic c;
        logic pp;
        c  = 1'b0;
        pp = 1'b1;
        for (int j = C_NS - 1; j >= 0; j--) begin
            if (j < k) begin
                c  = c | (gg[j] & pp);
                pp = pp & gp[j];
            end
        end
        return c | (pp & c0);
    endfunction

    assign w_c0    = ~i_cin_n;
    assign o_carry = f_cla(w_gg, w_gp, w_c0, C_NS);

    for (genvar k = 0; k < C_NS; k++) begin : g_slice
        logic [3:0] w_a4;
        logic [3:0] w_b4;
        logic [3:0] w_p;
        logic [3:0] w_g;
        logic [3:0] w_ci;
        logic [3:0] w_f;

        assign w_a4 = i_a[4*k +: 4];
        assign w_b4 = i_b[4*k +: 4];
        assign w_p  = w_a4 | (w_b4 & {4{i_s[0]}}) | (~w_b4 & {4{i_s[1]}});
        assign w_g  = (w_a4 & ~w_b4 & {4{i_s[2]}}) | (w_a4 & w_b4 & {4{i_s[3]}});

        assign w_cslice[k] = f_cla(w_gg, w_gp, w_c0, k);

        assign w_ci[0] = w_cslice[k];
        assign w_ci[1] = w_g[0] | (w_p[0] & w_cslice[k]);
        assign w_ci[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_cslice[k]);
        assign w_ci[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                       | (w_p[2] & w_p[1] & w_p[0] & w_cslice[k]);

        assign w_gg[k] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                       | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        assign w_gp[k] = &w_p;

        // Logic mode forces the carry term high, which yields the inverted 181 logic set.
        assign w_f = w_p ^ w_g ^ (i_m ? 4'hF : w_ci);
        assign o_f[4*k +: 4] = w_f;
        assign o_eq[k]       = &w_f;

        if (k == C_NS - 1) begin : g_msb
            assign o_c_msb = w_ci[3];
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_md.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_md                                                               |
// | 181-style ALU with iterative MUL and optional DIV (ALU_MD_DIV_EN).   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_md
    import alu_md_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk_sys,
    input  logic         clr_,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [0:W-1] a,
    input  logic [0:W-1] b,
    input  logic [3:0]   s,
    input  logic         saryt,
    input  logic         cin_,
    output logic         busy,
    output logic         done,
    output logic [0:W-1] f,
    output logic [0:W-1] fx,
    output logic         carry,
    output logic         zsum,
    output logic         j$,
    output logic         ovf,
    output logic         err
);

    localparam int C_CNT_W = $clog2(W + 1);

    state_t             r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [3:0]         r_s;
    logic               r_saryt;
    logic               r_cin_n;
    logic [W-1:0]       r_hi;
    logic [W-1:0]       r_lo;
    logic [C_CNT_W-1:0] r_cnt;

    logic [W-1:0]   w_ca;
    logic [W-1:0]   w_cb;
    logic [3:0]     w_cs;
    logic           w_cm;
    logic           w_ccin_n;
    logic [W-1:0]   w_cf;
    logic           w_cco;
    logic [W/4-1:0] w_ceq;
    logic           w_cmsb;

    // One core serves the ALU op and the add/subtract step of each iteration.
    always_comb begin
        w_ca     = r_a;
        w_cb     = r_b;
        w_cs     = r_s;
        w_cm     = ~r_saryt;
        w_ccin_n = r_cin_n;
        case (r_state)
            MUL: begin
                w_ca     = r_hi;
                w_cb     = r_a;
                w_cs     = S_ADD;
                w_cm     = 1'b0;
                w_ccin_n = 1'b1;
            end
`ifdef ALU_MD_DIV_EN
            DIV: begin
                w_ca     = {r_hi[W-2:0], r_lo[W-1]};
                w_cb     = r_b;
                w_cs     = S_SUB;
                w_cm     = 1'b0;
                w_ccin_n = 1'b0;
            end
`endif
            default: begin
            end
        endcase
    end

    alu_core_w #(.W(W)) u_core (
        .i_a     (w_ca),
        .i_b     (w_cb),
        .i_s     (w_cs),
        .i_m     (w_cm),
        .i_cin_n (w_ccin_n),
        .o_f     (w_cf),
        .o_carry (w_cco),
        .o_eq    (w_ceq),
        .o_c_msb (w_cmsb)
    );

    logic         w_last;
    logic         w_addsub;
    logic [W-1:0] w_sum;
    logic [W-1:0] w_mul_hi;
    logic [W-1:0] w_mul_lo;

    assign w_last   = (r_cnt == C_CNT_W'(W - 1));
    assign w_addsub = r_saryt & ((r_s == S_ADD) | (r_s == S_SUB));
    assign w_sum    = r_lo[0] ? w_cf : r_hi;
    assign w_mul_hi = {r_lo[0] & w_cco, w_sum[W-1:1]};
    assign w_mul_lo = {w_sum[0], r_lo[W-1:1]};

`ifdef ALU_MD_DIV_EN
    logic         w_qbit;
    logic [W-1:0] w_rem;
    logic [W-1:0] w_quo;

    // The shifted-out remainder MSB means the trial subtraction cannot borrow.
    assign w_qbit = r_hi[W-1] | w_cco;
    assign w_rem  = w_qbit ? w_cf : w_ca;
    assign w_quo  = {r_lo[W-2:0], w_qbit};
`endif

    always_ff @(posedge clk_sys or negedge clr_) begin
        if (!clr_) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_saryt <= 1'b0;
            r_cin_n <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            f       <= '0;
            fx      <= '0;
            carry   <= 1'b0;
            zsum    <= 1'b0;
            j$      <= 1'b0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_s     <= s;
                        r_saryt <= saryt;
                        r_cin_n <= cin_;
                        r_cnt   <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        case (op)
                            OP_ALU: r_state <= ALU;
                            OP_MUL: begin
                                r_hi    <= '0;
                                r_lo    <= b;
                                r_state <= MUL;
                            end
`ifdef ALU_MD_DIV_EN
                            OP_DIV: begin
                                if (b == '0) begin
                                    r_state <= ERR;
                                end else begin
                                    r_hi    <= '0;
                                    r_lo    <= a;
                                    r_state <= DIV;
                                end
                            end
`endif
                            OP_RSV:  r_state <= ERR;
                            default: r_state <= ERR;
                        endcase
                    end
                end
                ALU: begin
                    f       <= w_cf;
                    fx      <= '0;
                    carry   <= w_cco;
                    zsum    <= (w_cf == '0);
                    j$      <= &w_ceq;
                    ovf     <= w_addsub & (w_cmsb ^ w_cco);
                    done    <= 1'b1;
                    r_state <= FIN;
                end
                MUL: begin
                    r_hi  <= w_mul_hi;
                    r_lo  <= w_mul_lo;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        f       <= w_mul_lo;
                        fx      <= w_mul_hi;
                        carry   <= 1'b0;
                        ovf     <= 1'b0;
                        zsum    <= ({w_mul_hi, w_mul_lo} == '0);
                        j$      <= &w_mul_lo;
                        done    <= 1'b1;
                        r_state <= FIN;
                    end
                end
`ifdef ALU_MD_DIV_EN
                DIV: begin
                    r_hi  <= w_rem;
                    r_lo  <= w_quo;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        f       <= w_quo;
                        fx      <= w_rem;
                        carry   <= 1'b0;
                        ovf     <= 1'b0;
                        zsum    <= (w_quo == '0);
                        j$      <= &w_quo;
                        done    <= 1'b1;
                        r_state <= FIN;
                    end
                end
`endif
                ERR: begin
                    f       <= '1;
                    fx      <= r_a;
                    err     <= 1'b1;
                    carry   <= 1'b0;
                    ovf     <= 1'b0;
                    zsum    <= 1'b0;
                    j$      <= 1'b1;
                    done    <= 1'b1;
                    r_state <= FIN;
                end
                FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_md.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_md                                                            |
// | Table-driven scoreboard bench for alu_md (W=16).                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_md;
    import alu_md_pkg::*;

    localparam int W       = 16;
    localparam int LAT_MUL = W + 1;

    logic         clk_sys = 1'b0;
    logic         clr_    = 1'b0;
    logic         start   = 1'b0;
    logic [1:0]   op      = 2'b00;
    logic [0:W-1] a       = '0;
    logic [0:W-1] b       = '0;
    logic [3:0]   s       = 4'b0000;
    logic         saryt   = 1'b0;
    logic         cin_    = 1'b1;
    logic         busy;
    logic         done;
    logic [0:W-1] f;
    logic [0:W-1] fx;
    logic         carry;
    logic         zsum;
    logic         jeq;
    logic         ovf;
    logic         err;

    alu_md #(.W(W)) dut (
        .clk_sys (clk_sys),
        .clr_    (clr_),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .s       (s),
        .saryt   (saryt),
        .cin_    (cin_),
        .busy    (busy),
        .done    (done),
        .f       (f),
        .fx      (fx),
        .carry   (carry),
        .zsum    (zsum),
        .j$      (jeq),
        .ovf     (ovf),
        .err     (err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   s;
        logic         saryt;
        logic         cin_n;
        logic [W-1:0] ef;
        logic [W-1:0] efx;
        logic         ec;
        logic         ez;
        logic         ej;
        logic         eo;
        logic         ee;
        logic         cc;
        logic         co;
        int           lat;
    } vec_t;

    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t exp_q[$];
    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] vop, input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic [3:0] vs, input logic vsar, input logic vcin,
                                input logic [W-1:0] ef, input logic [W-1:0] efx,
                                input logic ec, input logic ez, input logic ej, input logic eo,
                                input logic ee, input logic cc, input logic co, input int lat);
        vec_t v;
        v.op = vop; v.a = va; v.b = vb; v.s = vs; v.saryt = vsar; v.cin_n = vcin;
        v.ef = ef; v.efx = efx; v.ec = ec; v.ez = ez; v.ej = ej; v.eo = eo; v.ee = ee;
        v.cc = cc; v.co = co; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_out(input vec_t e, input int cyc);
        chk("latency", 64'(cyc), 64'(e.lat));
        chk("f", 64'(f), 64'(e.ef));
        chk("fx", 64'(fx), 64'(e.efx));
        chk("err", 64'(err), 64'(e.ee));
        chk("zsum", 64'(zsum), 64'(e.ez));
        chk("j$", 64'(jeq), 64'(e.ej));
        if (e.cc) chk("carry", 64'(carry), 64'(e.ec));
        if (e.co) chk("ovf", 64'(ovf), 64'(e.eo));
    endtask

    // poke >= 1 raises a stray start at that cycle of the operation.
    task automatic run_op(input vec_t v, input int poke);
        int   cyc;
        bit   got;
        vec_t e;
        @(negedge clk_sys);
        op = v.op; a = v.a; b = v.b; s = v.s; saryt = v.saryt; cin_ = v.cin_n;
        start = 1'b1;
        exp_q.push_back(v);
        @(posedge clk_sys); #1;
        start = 1'b0;
        cyc   = 1;
        chk("busy_after_start", 64'(busy), 64'd1);
        a = ~v.a; b = ~v.b; s = ~v.s; cin_ = ~v.cin_n;
        got = 1'b0;
        while (!got && cyc <= 100) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (cyc == poke) begin
                    start = 1'b1;
                    op    = OP_ALU;
                end
                @(posedge clk_sys); #1;
                start = 1'b0;
                cyc++;
            end
        end
        e = exp_q.pop_front();
        if (!got) begin
            n_vec++;
            n_miss++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected %0d", cyc, e.lat);
        end else begin
            compare_out(e, cyc);
        end
        @(posedge clk_sys); #1;
        chk("done_pulse_end", 64'(done), 64'd0);
        chk("busy_end", 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic           rc;
        logic [W:0]     sum;
        logic [2*W-1:0] prod;

        //          op      a          b          s      sar cin  f          fx         c  z  j  o  e  cc co lat
        tbl.push_back(mk(OP_ALU, 16'h7FFF, 16'h0001, S_ADD, 1, 1, 16'h8000, 16'h0000, 0, 0, 0, 1, 0, 1, 1, 2));
        tbl.push_back(mk(OP_ALU, 16'h1234, 16'h1234, S_SUB, 1, 1, 16'hFFFF, 16'h0000, 0, 0, 1, 0, 0, 1, 1, 2));
        tbl.push_back(mk(OP_ALU, 16'h1234, 16'h1234, S_SUB, 1, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 0, 1, 1, 2));
        tbl.push_back(mk(OP_ALU, 16'h00F0, 16'h0F00, S_OR,  0, 1, 16'h0FF0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(OP_ALU, 16'hF0F0, 16'hFF00, S_AND, 0, 1, 16'hF000, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(OP_ALU, 16'hF0F0, 16'hFF00, S_XOR, 0, 1, 16'h0FF0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(OP_ALU, 16'h00FF, 16'h1234, S_A,   0, 1, 16'hFF00, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(OP_ALU, 16'h8000, 16'h8000, S_ADD, 1, 1, 16'h0000, 16'h0000, 1, 1, 0, 1, 0, 1, 1, 2));
        tbl.push_back(mk(OP_ALU, 16'h0001, 16'h0001, S_ADD, 1, 0, 16'h0003, 16'h0000, 0, 0, 0, 0, 0, 1, 1, 2));
        tbl.push_back(mk(OP_ALU, 16'h0005, 16'h0007, S_SUB, 1, 0, 16'hFFFE, 16'h0000, 0, 0, 0, 0, 0, 1, 1, 2));
        tbl.push_back(mk(OP_MUL, 16'hFFFF, 16'hFFFF, S_A,   0, 1, 16'h0001, 16'hFFFE, 0, 0, 0, 0, 0, 1, 1, LAT_MUL));
        tbl.push_back(mk(OP_MUL, 16'h0000, 16'h1234, S_A,   0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 1, 1, LAT_MUL));
        tbl.push_back(mk(OP_MUL, 16'h00FF, 16'h0101, S_A,   0, 1, 16'hFFFF, 16'h0000, 0, 0, 1, 0, 0, 1, 1, LAT_MUL));
        tbl.push_back(mk(OP_RSV, 16'hABCD, 16'h0001, S_A,   0, 1, 16'hFFFF, 16'hABCD, 0, 0, 1, 0, 1, 0, 0, 2));
        tbl.push_back(mk(OP_ALU, 16'h0002, 16'h0003, S_ADD, 1, 1, 16'h0005, 16'h0000, 0, 0, 0, 0, 0, 1, 1, 2));
        tbl.push_back(mk(OP_DIV, 16'h1234, 16'h0000, S_A,   0, 1, 16'hFFFF, 16'h1234, 0, 0, 1, 0, 1, 0, 0, 2));
`ifdef ALU_MD_DIV_EN
        tbl.push_back(mk(OP_DIV, 16'd100,  16'd7,    S_A,   0, 1, 16'd14,   16'd2,    0, 0, 0, 0, 0, 0, 0, LAT_MUL));
        tbl.push_back(mk(OP_DIV, 16'hFFFF, 16'h0001, S_A,   0, 1, 16'hFFFF, 16'h0000, 0, 0, 1, 0, 0, 0, 0, LAT_MUL));
        tbl.push_back(mk(OP_DIV, 16'h1234, 16'h1235, S_A,   0, 1, 16'h0000, 16'h1234, 0, 1, 0, 0, 0, 0, 0, LAT_MUL));
`else
        tbl.push_back(mk(OP_DIV, 16'd100,  16'd7,    S_A,   0, 1, 16'hFFFF, 16'd100,  0, 0, 1, 0, 1, 0, 0, 2));
`endif

        // Reset state
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_f", 64'(f), 64'd0);
        chk("rst_fx", 64'(fx), 64'd0);
        chk("rst_carry", 64'(carry), 64'd0);
        chk("rst_zsum", 64'(zsum), 64'd0);
        chk("rst_j$", 64'(jeq), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(negedge clk_sys);
        clr_ = 1'b1;

        foreach (tbl[i]) run_op(tbl[i], -1);

        for (int i = 0; i < 6; i++) begin
            ra  = W'($urandom_range(0, 65535));
            rb  = W'($urandom_range(0, 65535));
            rc  = 1'($urandom_range(0, 1));
            sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, ~rc};
            run_op(mk(OP_ALU, ra, rb, S_ADD, 1, rc, sum[W-1:0], '0, sum[W],
                      (sum[W-1:0] == '0), (sum[W-1:0] == '1),
                      (ra[W-1] == rb[W-1]) && (sum[W-1] != ra[W-1]), 0, 1, 1, 2), -1);
            prod = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
            run_op(mk(OP_MUL, ra, rb, S_A, 0, 1, prod[W-1:0], prod[2*W-1:W], 0,
                      (prod == '0), (prod[W-1:0] == '1), 0, 0, 1, 1, LAT_MUL), -1);
        end

        // Stray start at cycle 5 of a multiply must be dropped.
        run_op(mk(OP_MUL, 16'hFFFF, 16'hFFFF, S_A, 0, 1, 16'h0001, 16'hFFFE, 0, 0, 0, 0, 0, 1, 1, LAT_MUL), 5);

        // Asynchronous clear in the middle of a multiply.
        @(negedge clk_sys);
        op = OP_MUL; a = 16'hFFFF; b = 16'h0003; start = 1'b1;
        @(posedge clk_sys); #1;
        start = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        chk("mid_busy", 64'(busy), 64'd1);
        #2;
        clr_ = 1'b0;
        #1;
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        chk("clr_f", 64'(f), 64'd0);
        chk("clr_fx", 64'(fx), 64'd0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        clr_ = 1'b1;
        run_op(mk(OP_ALU, 16'h00F0, 16'h0F00, S_OR, 0, 1, 16'h0FF0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 2), -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
